// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared geometry constants and FSM state encodings for the CNN window scheduler
package cnn_pkg;

    localparam int IMG_W    = 28;
    localparam int K        = 5;
    localparam int PIX_W    = 8;
    localparam int OUT_N    = IMG_W - K + 1;
    localparam int ROW_BITS = IMG_W * PIX_W;
    localparam int WIN_BITS = K * K * PIX_W;

    localparam logic [4:0] LAST_POS = 5'(OUT_N - 1);

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_PRIME  = 3'd1;
    localparam state_t ST_KICK   = 3'd2;
    localparam state_t ST_STREAM = 3'd3;
    localparam state_t ST_DRAIN  = 3'd4;
    localparam state_t ST_WAIT   = 3'd5;

endpackage

// File: rtl/cnn_line_buffer.sv
// rtl/cnn_line_buffer.sv - five-row image line buffer with staging row and KxK window extract
module cnn_line_buffer
    import cnn_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [ROW_BITS-1:0] i_row,
    input  logic                i_prime_load,
    input  logic                i_stage_load,
    input  logic                i_advance,
    input  logic                i_use_next,
    input  logic [4:0]          i_col,
    output logic [WIN_BITS-1:0] o_window
);

    logic [ROW_BITS-1:0] r_rows [K];
    logic [ROW_BITS-1:0] r_stage;
    logic [ROW_BITS-1:0] w_view [K];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < K; i++) r_rows[i] <= '0;
            r_stage <= '0;
        end else begin
            if (i_prime_load || i_advance) begin
                for (int i = 0; i < K - 1; i++) r_rows[i] <= r_rows[i+1];
                r_rows[K-1] <= i_prime_load ? i_row : r_stage;
            end
            if (i_stage_load) r_stage <= i_row;
        end
    end

    // The "next" view is what the rows will hold after the advance, so the
    // first window of a new row group can be registered on the advancing edge.
    always_comb begin
        for (int i = 0; i < K - 1; i++) w_view[i] = i_use_next ? r_rows[i+1] : r_rows[i];
        w_view[K-1] = i_use_next ? r_stage : r_rows[K-1];
    end

    always_comb begin
        o_window = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                o_window[(i*K+j)*PIX_W +: PIX_W] = w_view[i][(int'(i_col)+j)*PIX_W +: PIX_W];
            end
        end
    end

endmodule

// File: rtl/cnn_window_scheduler.sv
// rtl/cnn_window_scheduler.sv - inference sequencer feeding 5x5 windows to the CNN; optional CNN_SCHED_STATS_EN adds o_stat_cycles
module cnn_window_scheduler
    import cnn_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
`ifdef CNN_SCHED_STATS_EN
    output logic [15:0]         o_stat_cycles,
`endif
    input  logic                i_go,
    output logic                o_busy,
    output logic [3:0]          o_result,
    output logic                o_result_valid,
    output logic                o_mem_rd,
    output logic [4:0]          o_mem_addr,
    input  logic [ROW_BITS-1:0] i_mem_rdata,
    output logic                o_cnn_nrst,
    output logic                o_cnn_start,
    output logic [4:0]          o_cnn_x,
    output logic [4:0]          o_cnn_y,
    output logic [WIN_BITS-1:0] o_cnn_img,
    input  logic                i_cnn_done,
    input  logic [3:0]          i_cnn_out
);

    state_t              r_state;
    logic [2:0]          r_cnt;
    logic [4:0]          r_wx;
    logic [4:0]          r_wy;
    logic [4:0]          r_x;
    logic [4:0]          r_y;
    logic [WIN_BITS-1:0] r_img;
    logic [3:0]          r_result;
    logic                r_result_valid;
    logic                r_rd_d;

    logic                w_prime_rd;
    logic                w_stream_rd;
    logic                w_mem_rd;
    logic [4:0]          w_mem_addr;
    logic                w_row_end;
    logic                w_use_next;
    logic [4:0]          w_col;
    logic [WIN_BITS-1:0] w_window;

    assign w_prime_rd  = (r_state == ST_PRIME) && (r_cnt < 3'd5);
    assign w_stream_rd = (r_state == ST_STREAM) && (r_wy == 5'd0) && (r_wx < LAST_POS);
    assign w_mem_rd    = w_prime_rd || w_stream_rd;
    assign w_mem_addr  = w_prime_rd  ? {2'b00, r_cnt} :
                         w_stream_rd ? r_wx + 5'(K)   : 5'd0;

    // The column selected here is the one registered onto o_cnn_img at the
    // coming edge, i.e. the window one step ahead of the counters.
    assign w_row_end  = (r_state == ST_STREAM) && (r_wy == LAST_POS);
    assign w_use_next = w_row_end && (r_wx != LAST_POS);
    assign w_col      = ((r_state == ST_STREAM) && (r_wy != LAST_POS)) ? r_wy + 5'd1 : 5'd0;

    cnn_line_buffer u_line_buffer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_row        (i_mem_rdata),
        .i_prime_load ((r_state == ST_PRIME) && r_rd_d),
        .i_stage_load ((r_state == ST_STREAM) && r_rd_d),
        .i_advance    (w_use_next),
        .i_use_next   (w_use_next),
        .i_col        (w_col),
        .o_window     (w_window)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_wx           <= '0;
            r_wy           <= '0;
            r_x            <= '0;
            r_y            <= '0;
            r_img          <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_rd_d         <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            r_rd_d         <= w_mem_rd;
            case (r_state)
                ST_IDLE: begin
                    if (i_go) begin
                        r_state <= ST_PRIME;
                        r_cnt   <= '0;
                    end
                end
                ST_PRIME: begin
                    if (r_cnt == 3'd5) r_state <= ST_KICK;
                    else               r_cnt   <= r_cnt + 3'd1;
                end
                ST_KICK: begin
                    r_wx    <= '0;
                    r_wy    <= '0;
                    r_x     <= '0;
                    r_y     <= '0;
                    r_img   <= w_window;
                    r_state <= ST_STREAM;
                end
                ST_STREAM: begin
                    r_x <= r_wx;
                    r_y <= r_wy;
                    if (w_row_end) begin
                        if (r_wx == LAST_POS) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_wx  <= r_wx + 5'd1;
                            r_wy  <= '0;
                            r_img <= w_window;
                        end
                    end else begin
                        r_wy  <= r_wy + 5'd1;
                        r_img <= w_window;
                    end
                end
                ST_DRAIN: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_cnn_done) begin
                        r_result       <= i_cnn_out;
                        r_result_valid <= 1'b1;
                        r_state        <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef CNN_SCHED_STATS_EN
    logic [15:0] r_run_cnt;
    logic [15:0] r_stat;
    logic [16:0] w_run_end;

    // At the DONE edge the count still lacks the DONE cycle and the RESULT_VALID cycle.
    assign w_run_end = {1'b0, r_run_cnt} + 17'd2;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_run_cnt <= '0;
            r_stat    <= '0;
        end else if (r_state == ST_IDLE) begin
            if (i_go) r_run_cnt <= 16'd1;
        end else if ((r_state == ST_WAIT) && i_cnn_done) begin
            r_stat <= w_run_end[16] ? 16'hFFFF : w_run_end[15:0];
        end else if (r_run_cnt != 16'hFFFF) begin
            r_run_cnt <= r_run_cnt + 16'd1;
        end
    end

    assign o_stat_cycles = r_stat;
`endif

    assign o_busy         = (r_state != ST_IDLE);
    assign o_result       = r_result;
    assign o_result_valid = r_result_valid;
    assign o_mem_rd       = w_mem_rd;
    assign o_mem_addr     = w_mem_addr;
    assign o_cnn_nrst     = ~i_rst;
    assign o_cnn_start    = (r_state == ST_KICK);
    assign o_cnn_x        = r_x;
    assign o_cnn_y        = r_y;
    assign o_cnn_img      = r_img;

endmodule
